// File: rtl/ram_fifo_stream_adapter.sv
// Valid/ready stream adapter around a RAM block used in FIFO mode: upstream words go to the RAM
// write port, and reads refill a 2-entry output buffer that feeds the downstream stream.
module ram_fifo_stream_adapter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned AFULL_THRESH = 448,
    localparam int unsigned CW          = $clog2(DEPTH + 3)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic [DATA_W-1:0] M_DATA,
    input  logic              FLUSH,
    output logic              RAM_WEN,
    output logic [31:0]       RAM_WDATA,
    output logic              RAM_REN,
    input  logic [31:0]       RAM_RDATA,
    output logic              RAM_FFLUSH,
    output logic [CW-1:0]     LEVEL,
    output logic              EMPTY,
    output logic              ALMOST_FULL
);

    typedef enum logic [1:0] {StFlush0, StFlush1, StRun} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]     level_q, level_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];

    logic run, clear, pop, capture, tail;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFlush0: state_d = StFlush1;
            StFlush1: state_d = StRun;
            StRun:    if (FLUSH) state_d = StFlush0;
            default:  state_d = StFlush0;
        endcase
    end

    // Handshake outputs depend on registered state only, never on S_VALID or M_READY.
    always_comb begin
        run        = (state_q == StRun);
        RAM_FFLUSH = !run;
        S_READY    = run && (ram_cnt_q < CW'(DEPTH));
        RAM_WEN    = S_VALID && S_READY;
        RAM_REN    = run && (ram_cnt_q != '0) && ((buf_cnt_q + 2'(inflight_q)) < 2'd2);
        M_VALID    = (buf_cnt_q != 2'd0);
        M_DATA     = buf_q[rd_ptr_q];
        pop        = M_VALID && M_READY;
        capture    = run && inflight_q;
        tail       = rd_ptr_q ^ buf_cnt_q[0];
        // Entering a flush empties everything at once; the RAM pointers are reset by RAM_FFLUSH.
        clear      = !run || FLUSH;
        RAM_WDATA  = '0;
        if (run) RAM_WDATA[DATA_W-1:0] = S_DATA;
    end

    always_comb begin
        ram_cnt_d  = ram_cnt_q + CW'(RAM_WEN) - CW'(RAM_REN);
        inflight_d = RAM_REN;
        buf_cnt_d  = buf_cnt_q + 2'(capture) - 2'(pop);
        rd_ptr_d   = rd_ptr_q ^ pop;
        buf_d      = buf_q;
        if (capture) buf_d[tail] = RAM_RDATA[DATA_W-1:0];
        if (clear) begin
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            buf_cnt_d  = 2'd0;
            rd_ptr_d   = 1'b0;
            buf_d[0]   = '0;
            buf_d[1]   = '0;
        end
        level_d = ram_cnt_d + CW'(inflight_d) + CW'(buf_cnt_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StFlush0;
            ram_cnt_q  <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            rd_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            ram_cnt_q  <= ram_cnt_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    assign LEVEL       = level_q;
    assign EMPTY       = (level_q == '0);
    assign ALMOST_FULL = (level_q >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_ram_fifo_stream_adapter.sv
// Directed bench for ram_fifo_stream_adapter with a behavioural RAM FIFO (DEPTH=8, 16-bit data).
module tb_ram_fifo_stream_adapter;

    localparam int unsigned DW = 16;
    localparam int unsigned DP = 8;
    localparam int unsigned AT = 6;
    localparam int unsigned CW = $clog2(DP + 3);

    logic          CLK, RST, S_VALID, S_READY, M_VALID, M_READY, FLUSH;
    logic          RAM_WEN, RAM_REN, RAM_FFLUSH, EMPTY, ALMOST_FULL;
    logic [DW-1:0] S_DATA, M_DATA;
    logic [31:0]   RAM_WDATA, RAM_RDATA;
    logic [CW-1:0] LEVEL;

    int total = 0;
    int bad   = 0;

    ram_fifo_stream_adapter #(
        .DATA_W       (DW),
        .DEPTH        (DP),
        .AFULL_THRESH (AT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .S_DATA      (S_DATA),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .M_DATA      (M_DATA),
        .FLUSH       (FLUSH),
        .RAM_WEN     (RAM_WEN),
        .RAM_WDATA   (RAM_WDATA),
        .RAM_REN     (RAM_REN),
        .RAM_RDATA   (RAM_RDATA),
        .RAM_FFLUSH  (RAM_FFLUSH),
        .LEVEL       (LEVEL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM in FIFO mode: read data appears the cycle after RAM_REN.
    logic [31:0] ram_mem [$];
    logic [31:0] ram_rd_q = 32'h0;
    assign RAM_RDATA = ram_rd_q;
    always @(posedge CLK) begin
        if (RAM_FFLUSH) begin
            ram_mem.delete();
        end else begin
            if (RAM_REN) begin
                if (ram_mem.size() > 0) ram_rd_q <= ram_mem.pop_front();
                else ram_rd_q <= 32'hDEAD_BEEF;
            end
            if (RAM_WEN) ram_mem.push_back(RAM_WDATA);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_ready"}, S_READY, 0);
        chk({p, "_m_valid"}, M_VALID, 0);
        chk({p, "_ram_wen"}, RAM_WEN, 0);
        chk({p, "_ram_ren"}, RAM_REN, 0);
        chk({p, "_ram_fflush"}, RAM_FFLUSH, 1);
        chk({p, "_level"}, LEVEL, 0);
        chk({p, "_empty"}, EMPTY, 1);
        chk({p, "_afull"}, ALMOST_FULL, 0);
        chk({p, "_m_data"}, M_DATA, 0);
        chk({p, "_ram_wdata"}, RAM_WDATA, 0);
    endtask

    task automatic wait_mvalid(input string tag);
        for (int c = 0; c < 10 && !M_VALID; c++) tick();
        chk(tag, M_VALID, 1);
    endtask

    initial begin
        int acc, k, sent, rcv, both;
        logic [15:0] exp_q [$];
        logic [15:0] e;

        RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0; FLUSH = 1'b0;
        tick();
        tick();
        chk_reset("rst");

        // Flush sequence after reset release.
        RST = 1'b0;
        chk("flush0_fflush", RAM_FFLUSH, 1);
        chk("flush0_s_ready", S_READY, 0);
        tick();
        chk("flush1_fflush", RAM_FFLUSH, 1);
        chk("flush1_s_ready", S_READY, 0);
        tick();
        chk("run_fflush", RAM_FFLUSH, 0);
        chk("run_s_ready", S_READY, 1);

        // T1: single word latency.
        S_VALID = 1'b1; S_DATA = 16'h0011;
        #1;
        chk("t1_wen", RAM_WEN, 1);
        chk("t1_wdata", RAM_WDATA, 32'h0000_0011);
        chk("t1_ren_t0", RAM_REN, 0);
        tick();
        S_VALID = 1'b0;
        chk("t1_ren_t1", RAM_REN, 1);
        chk("t1_level_t1", LEVEL, 1);
        tick();
        chk("t1_mvalid_t2", M_VALID, 0);
        tick();
        chk("t1_mvalid_t3", M_VALID, 1);
        chk("t1_mdata_t3", M_DATA, 16'h0011);
        M_READY = 1'b1;
        tick();
        M_READY = 1'b0;
        chk("t1_level_end", LEVEL, 0);
        chk("t1_empty_end", EMPTY, 1);

        // T2: fill with the sink stalled; LEVEL climbs one per cycle to DEPTH+2.
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            S_VALID = 1'b1;
            S_DATA  = 16'(16'h00A0 + acc);
            chk("t2_level", LEVEL, (i > 10) ? 10 : i);
            chk("t2_afull", ALMOST_FULL, (i >= 6) ? 1 : 0);
            chk("t2_s_ready", S_READY, (i < 10) ? 1 : 0);
            if (S_READY) acc++;
            tick();
        end
        S_VALID = 1'b0;
        chk("t2_accepted", acc, 10);
        chk("t2_level_full", LEVEL, 10);
        chk("t2_head", M_DATA, 16'h00A0);
        M_READY = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            if (M_VALID) begin
                chk("t2_drain", M_DATA, 16'h00A0 + k);
                k++;
            end
            tick();
        end
        M_READY = 1'b0;
        chk("t2_drained", k, 10);
        chk("t2_level_end", LEVEL, 0);

        // T3: continuous stream with the sink always ready.
        M_READY = 1'b1;
        sent = 0; rcv = 0; both = 0;
        for (int c = 0; c < 400 && rcv < 100; c++) begin
            S_VALID = (sent < 100);
            S_DATA  = 16'(sent);
            #1;
            if (RAM_WEN && RAM_REN) both++;
            if (S_VALID && S_READY) sent++;
            if (M_VALID) begin
                chk("t3_order", M_DATA, rcv);
                rcv++;
            end
            @(posedge CLK);
            #1;
        end
        S_VALID = 1'b0;
        chk("t3_count", rcv, 100);
        chk("t3_wen_ren_overlap", (both > 0) ? 1 : 0, 1);
        chk("t3_level_end", LEVEL, 0);

        // T4: random source and sink against a scoreboard.
        sent = 0; rcv = 0;
        for (int c = 0; c < 4000 && rcv < 300; c++) begin
            S_VALID = (sent < 300) && ($urandom_range(9) < 7);
            S_DATA  = 16'(16'hC000 + sent);
            M_READY = ($urandom_range(1) == 1);
            #1;
            if (S_VALID && S_READY) begin
                exp_q.push_back(S_DATA);
                sent++;
            end
            if (M_VALID && M_READY) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                chk("t4_order", M_DATA, e);
                rcv++;
            end
            @(posedge CLK);
            #1;
        end
        S_VALID = 1'b0; M_READY = 1'b0;
        chk("t4_count", rcv, 300);
        chk("t4_empty", EMPTY, 1);

        // T5: flush while a read is being issued at LEVEL=5.
        for (int i = 0; i < 5; i++) begin
            S_VALID = 1'b1;
            S_DATA  = 16'(16'h00B0 + i);
            tick();
        end
        S_DATA  = 16'h00B5;
        M_READY = 1'b1;
        chk("t5_pre_level", LEVEL, 5);
        chk("t5_pre_head", M_DATA, 16'h00B0);
        tick();
        S_VALID = 1'b0; M_READY = 1'b0; FLUSH = 1'b1;
        chk("t5_ren", RAM_REN, 1);
        chk("t5_level", LEVEL, 5);
        tick();
        chk("t5_f0_fflush", RAM_FFLUSH, 1);
        chk("t5_f0_level", LEVEL, 0);
        chk("t5_f0_mvalid", M_VALID, 0);
        chk("t5_f0_s_ready", S_READY, 0);
        tick();
        chk("t5_f1_fflush", RAM_FFLUSH, 1);
        tick();
        FLUSH = 1'b0;
        chk("t5_run_fflush", RAM_FFLUSH, 0);
        chk("t5_run_mvalid", M_VALID, 0);
        S_VALID = 1'b1; S_DATA = 16'h005A;
        tick();
        S_VALID = 1'b0;
        wait_mvalid("t5_wait");
        chk("t5_first_pop", M_DATA, 16'h005A);
        M_READY = 1'b1;
        tick();
        M_READY = 1'b0;
        chk("t5_level_end", LEVEL, 0);

        // T6: synchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            S_VALID = 1'b1;
            S_DATA  = 16'(16'h00D0 + i);
            tick();
        end
        S_VALID = 1'b0;
        chk("t6_mid_mvalid", M_VALID, 1);
        RST = 1'b1;
        tick();
        chk_reset("t6");
        RST = 1'b0;
        chk("t6_f0_fflush", RAM_FFLUSH, 1);
        tick();
        chk("t6_f1_fflush", RAM_FFLUSH, 1);
        chk("t6_f1_s_ready", S_READY, 0);
        tick();
        chk("t6_run_s_ready", S_READY, 1);
        S_VALID = 1'b1; S_DATA = 16'hFFE1;
        #1;
        chk("t6_wdata_zext", RAM_WDATA, 32'h0000_FFE1);
        tick();
        S_DATA = 16'h00E2;
        tick();
        S_VALID = 1'b0;
        M_READY = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            if (M_VALID) begin
                chk("t6_order", M_DATA, (k == 0) ? 16'hFFE1 : 16'h00E2);
                k++;
            end
            tick();
        end
        M_READY = 1'b0;
        chk("t6_count", k, 2);
        chk("t6_empty", EMPTY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
